mcu_nibble_tx: RTL

FPGA-to-MCU result transmitter for the PIC32 coprocessor port link. Accepts 8-bit results from FPGA-side compute logic through a valid/ready interface and buffers them in a small FIFO. Sends each byte to the MCU over the 4-bit port_d bus as two nibbles, high nibble first. Each nibble uses a four-phase req/ack handshake: tx_req goes to an MCU input pin, mcu_ack comes from port_f[1].

---
 rtl/mcu_port_pkg.sv | 19 +
 rtl/mcu_tx_fifo.sv | 59 +++++
 rtl/mcu_nibble_tx.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mcu_port_pkg.sv
// Shared definitions for the FPGA-to-MCU nibble transmitter.
package mcu_port_pkg;

  localparam int NIBBLE_W            = 4;
  localparam int BYTE_W              = 8;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Transmitter states: each nibble walks SETUP -> REQ -> REL
  typedef enum logic [2:0] {
    IDLE,
    HI_SETUP,
    HI_REQ,
    HI_REL,
    LO_SETUP,
    LO_REQ,
    LO_REL
  } mcu_tx_state_t;

endpackage

// File: rtl/mcu_tx_fifo.sv
// Circular result buffer with wrapping pointers and an explicit occupancy count.
// The head is read combinationally so the transmitter can pop and capture it
// in the same cycle.
module mcu_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push while full is refused even if a pop frees a slot this cycle
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates every read
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mcu_nibble_tx.sv
// Sends buffered result bytes to the MCU as two nibbles (high first), each
// framed by a four-phase tx_req/mcu_ack handshake.
module mcu_nibble_tx
  import mcu_port_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          in_valid,
  input  logic [BYTE_W-1:0]             in_data,
  output logic                          in_ready,
  input  logic                          mcu_ack,
  output logic [NIBBLE_W-1:0]           port_d,
  output logic                          tx_req,
  output logic                          nibble_hi,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;

  mcu_tx_state_t          state;
  mcu_tx_state_t          state_next;
  logic [BYTE_W-1:0]      tx_byte;
  logic [BYTE_W-1:0]      tx_byte_next;
  logic [NIBBLE_W-1:0]    port_d_next;
  logic                   tx_req_next;
  logic                   nibble_hi_next;

  logic                   fifo_pop;
  logic [BYTE_W-1:0]      fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;

  mcu_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready = ~fifo_full;

  // Bring the MCU acknowledge into the clock domain before the FSM looks at it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ack_sync <= '0;
    else          ack_sync <= {ack_sync[SYNC_STAGES-2:0], mcu_ack};
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // State and registered link outputs; reset drops any byte in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      tx_byte   <= '0;
      port_d    <= '0;
      tx_req    <= 1'b0;
      nibble_hi <= 1'b0;
    end else begin
      state     <= state_next;
      tx_byte   <= tx_byte_next;
      port_d    <= port_d_next;
      tx_req    <= tx_req_next;
      nibble_hi <= nibble_hi_next;
    end
  end

  // Handshake sequencing; port_d only changes on entry to a SETUP state
  always_comb begin
    state_next     = state;
    tx_byte_next   = tx_byte;
    port_d_next    = port_d;
    tx_req_next    = tx_req;
    nibble_hi_next = nibble_hi;
    fifo_pop       = 1'b0;
    case (state)
      IDLE: begin
        // A stuck-high ack means the MCU has not released yet; do not start
        if (!fifo_empty && !ack_s) begin
          fifo_pop       = 1'b1;
          tx_byte_next   = fifo_head;
          port_d_next    = fifo_head[BYTE_W-1:NIBBLE_W];
          nibble_hi_next = 1'b1;
          state_next     = HI_SETUP;
        end
      end
      HI_SETUP: begin
        tx_req_next = 1'b1;
        state_next  = HI_REQ;
      end
      HI_REQ: begin
        if (ack_s) begin
          tx_req_next = 1'b0;
          state_next  = HI_REL;
        end
      end
      HI_REL: begin
        if (!ack_s) begin
          port_d_next    = tx_byte[NIBBLE_W-1:0];
          nibble_hi_next = 1'b0;
          state_next     = LO_SETUP;
        end
      end
      LO_SETUP: begin
        tx_req_next = 1'b1;
        state_next  = LO_REQ;
      end
      LO_REQ: begin
        if (ack_s) begin
          tx_req_next = 1'b0;
          state_next  = LO_REL;
        end
      end
      LO_REL: begin
        if (!ack_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
